div_unit: RTL and testbench

- Multi-cycle iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU operations.
- Sits in the execute stage beside the combinational ALU and takes the same operand buses and iControl opcode.
- Stalls the pipeline while it computes.
- Its oResult feeds the execute-stage result mux, which is downstream of both units.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 198 +++++++++++++++++++
 tb/tb_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared execute-stage definitions: divide opcodes (ALU encoding), datapath width, zero constant.
package div_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OPADD  = 5'd0;
  localparam logic [4:0] OPDIV  = 5'd16;
  localparam logic [4:0] OPDIVU = 5'd17;
  localparam logic [4:0] OPREM  = 5'd18;
  localparam logic [4:0] OPREMU = 5'd19;

  localparam logic [XLEN-1:0] ZERO = '0;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU) || (op == OPREM) || (op == OPREMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dbit,
  output logic [XLEN-1:0] rem_out,
  output logic            qbit
);

  logic [XLEN:0]   trial;
  logic [XLEN+1:0] diff;
  logic            unused_diff_bit;

  assign trial = {rem_in, dbit};
  assign diff  = {1'b0, trial} - {2'b00, divisor};
  assign qbit  = ~diff[XLEN+1];
  // The remainder is always below the divisor, so the kept difference fits in XLEN bits.
  assign rem_out = qbit ? diff[XLEN-1:0] : trial[XLEN-1:0];
  assign unused_diff_bit = diff[XLEN];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; stalls the pipeline while busy.
// Optional last-result reuse cache enabled by defining DIV_RESULT_REUSE_EN.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN   = div_unit_pkg::XLEN,
  parameter int UNROLL = 1
) (
  input  logic            iCLK,
  input  logic            iRST_n,
  input  logic            iStart,
  input  logic [4:0]      iControl,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iFlush,
  output logic            oStall,
  output logic            oBusy,
  output logic            oValid,
  output logic [XLEN-1:0] oResult
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic signed [XLEN-1:0] cond_neg(input logic signed [XLEN-1:0] v,
                                                      input logic neg);
    return neg ? -v : v;
  endfunction

  state_t state_q, state_n;
  logic             accept, stall;
  logic [CNT_W-1:0] cnt_q;
  logic             op_rem_q, a_neg_q, b_neg_q;
  logic [XLEN-1:0]  quo_q, rem_q, dvs_q, res_q;

  logic            op_ok, op_sgn, op_rem, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div0, ovf, special, hit;
  logic [XLEN-1:0] spec_res, hit_res;
  logic signed [XLEN-1:0] q_fix, r_fix;

  assign op_ok   = is_div_op(iControl);
  assign op_sgn  = (iControl == OPDIV) || (iControl == OPREM);
  assign op_rem  = (iControl == OPREM) || (iControl == OPREMU);
  assign a_neg   = op_sgn & iA[XLEN-1];
  assign b_neg   = op_sgn & iB[XLEN-1];
  assign a_abs   = a_neg ? -iA : iA;
  assign b_abs   = b_neg ? -iB : iB;
  assign div0    = (iB == '0);
  assign ovf     = op_sgn && (iA == MIN_NEG) && (iB == '1);
  assign special = div0 | ovf;
  // Divide-by-zero takes priority: REM by zero returns the raw dividend.
  assign spec_res = div0 ? (op_rem ? iA : '1) : (op_rem ? '0 : MIN_NEG);

`ifdef DIV_RESULT_REUSE_EN
  logic            cache_vld_q, cache_sgn_q, pend_sgn_q;
  logic [XLEN-1:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;
  logic [XLEN-1:0] pend_a_q, pend_b_q;

  assign hit     = cache_vld_q && (iA == cache_a_q) && (iB == cache_b_q) && (op_sgn == cache_sgn_q);
  assign hit_res = op_rem ? cache_rem_q : cache_quo_q;
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  // Step chain: UNROLL restoring steps per clock, MSB-first through the dividend.
  logic [UNROLL:0][XLEN-1:0] rem_chain;
  logic [UNROLL-1:0]         qbits;
  logic [XLEN-1:0]           quo_next;

  assign rem_chain[0] = rem_q;
  for (genvar k = 0; k < UNROLL; k++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_chain[k]),
      .divisor (dvs_q),
      .dbit    (quo_q[XLEN-1-k]),
      .rem_out (rem_chain[k+1]),
      .qbit    (qbits[UNROLL-1-k])
    );
  end
  assign quo_next = {quo_q[XLEN-1-UNROLL:0], qbits};

  assign q_fix = cond_neg(quo_q, a_neg_q ^ b_neg_q);
  assign r_fix = cond_neg(rem_q, a_neg_q);

  always_comb begin
    state_n = state_q;
    accept  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept = iStart & op_ok & ~iFlush;
        stall  = accept;
        if (accept) state_n = (special | hit) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        stall = 1'b1;
        if (cnt_q == '0) state_n = S_FIX;
      end
      S_FIX: begin
        stall   = 1'b1;
        state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (iFlush) state_n = S_IDLE;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state_q <= S_IDLE;
    else         state_q <= state_n;
  end

  // Datapath: operand capture at accept, iteration in CALC, sign fix-up and result in FIX.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt_q    <= '0;
      op_rem_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
`ifdef DIV_RESULT_REUSE_EN
      cache_vld_q <= 1'b0;
      cache_sgn_q <= 1'b0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_quo_q <= '0;
      cache_rem_q <= '0;
      pend_sgn_q  <= 1'b0;
      pend_a_q    <= '0;
      pend_b_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_rem_q <= op_rem;
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            quo_q    <= a_abs;
            dvs_q    <= b_abs;
            rem_q    <= '0;
            cnt_q    <= CNT_LOAD;
            if (special)  res_q <= spec_res;
            else if (hit) res_q <= hit_res;
`ifdef DIV_RESULT_REUSE_EN
            pend_sgn_q <= op_sgn;
            pend_a_q   <= iA;
            pend_b_q   <= iB;
`endif
          end
        end
        S_CALC: begin
          rem_q <= rem_chain[UNROLL];
          quo_q <= quo_next;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        S_FIX: begin
          if (!iFlush) begin
            res_q <= op_rem_q ? r_fix : q_fix;
`ifdef DIV_RESULT_REUSE_EN
            cache_vld_q <= 1'b1;
            cache_sgn_q <= pend_sgn_q;
            cache_a_q   <= pend_a_q;
            cache_b_q   <= pend_b_q;
            cache_quo_q <= q_fix;
            cache_rem_q <= r_fix;
`endif
          end
        end
        default: ;
      endcase
`ifdef DIV_RESULT_REUSE_EN
      if (iFlush) cache_vld_q <= 1'b0;
`endif
    end
  end

  assign oStall  = stall;
  assign oBusy   = (state_q != S_IDLE);
  assign oValid  = (state_q == S_DONE);
  assign oResult = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed table-driven bench for div_unit plus hand sequences for flush, reset and reuse cases.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int LAT_FULL = 34;
  localparam int LAT_ONE  = 1;
  localparam int NVEC     = 15;
  localparam int BOUND    = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  ctrl;
  logic [31:0] a, b;
  logic        flush;
  logic        stall, busy, valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div_unit #(.XLEN(32), .UNROLL(1)) dut (
    .iCLK     (clk),
    .iRST_n   (rst_n),
    .iStart   (start),
    .iControl (ctrl),
    .iA       (a),
    .iB       (b),
    .iFlush   (flush),
    .oStall   (stall),
    .oBusy    (busy),
    .oValid   (valid),
    .oResult  (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive a request on a falling edge; return at the falling edge after the accept edge.
  task automatic start_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output logic acc_stall);
    @(negedge clk);
    start = 1'b1;
    ctrl  = op;
    a     = av;
    b     = bv;
    #1 acc_stall = stall;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles (starting at 1) until oValid is seen, counting stalled cycles on the way.
  task automatic wait_valid(output logic [31:0] res, output int lat, output int stalls);
    lat    = 1;
    stalls = 0;
    while (!valid && lat < BOUND) begin
      if (stall) stalls++;
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic run_and_check(input string name, input logic [4:0] op, input logic [31:0] av,
                               input logic [31:0] bv, input logic [31:0] exp_res, input int exp_lat);
    logic        acc_stall;
    logic [31:0] res;
    int          lat, stalls;
    start_op(op, av, bv, acc_stall);
    wait_valid(res, lat, stalls);
    check({name, "_res"}, res, exp_res);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_accstall"}, {31'd0, acc_stall}, 32'd1);
    check({name, "_stalls"}, 32'(stalls), 32'(exp_lat - 1));
    @(negedge clk);
    check({name, "_pulse"}, {30'd0, valid, busy}, 32'd0);
  endtask

  initial begin
    logic        acc_stall;
    logic [31:0] res;
    int          lat, stalls, nvalid;

    vecs[0]  = '{"divu_100_7",  OPDIVU, 32'd100,        32'd7,          32'd14,         LAT_FULL};
    vecs[1]  = '{"div_m7_2",    OPDIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  LAT_FULL};
    vecs[2]  = '{"remu_100_7",  OPREMU, 32'd100,        32'd7,          32'd2,          LAT_FULL};
    vecs[3]  = '{"div_7_m2",    OPDIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  LAT_FULL};
    vecs[4]  = '{"rem_m7_2",    OPREM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  LAT_FULL};
    vecs[5]  = '{"rem_7_m2",    OPREM,  32'd7,          32'hFFFF_FFFE,  32'd1,          LAT_FULL};
    vecs[6]  = '{"div_5_0",     OPDIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  LAT_ONE};
    vecs[7]  = '{"rem_5_0",     OPREM,  32'd5,          32'd0,          32'd5,          LAT_ONE};
    vecs[8]  = '{"div_ovf",     OPDIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  LAT_ONE};
    vecs[9]  = '{"rem_ovf",     OPREM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT_ONE};
    vecs[10] = '{"divu_big",    OPDIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          LAT_FULL};
    vecs[11] = '{"remu_5_0",    OPREMU, 32'd5,          32'd0,          32'd5,          LAT_ONE};
    vecs[12] = '{"remu_max_10", OPREMU, 32'hFFFF_FFFF,  32'd10,         32'd5,          LAT_FULL};
    vecs[13] = '{"divu_max_1",  OPDIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  LAT_FULL};
    vecs[14] = '{"div_m7_m2",   OPDIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          LAT_FULL};

    rst_n = 1'b0;
    start = 1'b0;
    ctrl  = OPADD;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", result, ZERO);
    check("reset_flags", {29'd0, valid, busy, stall}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++)
      run_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    // iStart while computing must not disturb the operation in flight.
    start_op(OPDIVU, 32'd100, 32'd7, acc_stall);
    repeat (3) @(negedge clk);
    start = 1'b1; ctrl = OPDIVU; a = 32'd1; b = 32'd1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_valid(res, lat, stalls);
    check("busy_start_res", res, 32'd14);
    check("busy_start_lat", 32'(lat), 32'(LAT_FULL - 13));

    // Non-divide opcode is ignored.
    @(negedge clk);
    start = 1'b1; ctrl = OPADD; a = 32'd10; b = 32'd2;
    #1 check("opadd_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("opadd_busy", {30'd0, busy, valid}, 32'd0);

    // Flush at CALC cycle 10.
    start_op(OPDIVU, 32'd12345, 32'd7, acc_stall);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 check("flush_busy", {30'd0, busy, valid}, 32'd0);
    check("flush_result", result, 32'd14);
    @(negedge clk);
    flush  = 1'b0;
    nvalid = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    check("flush_no_valid", 32'(nvalid), 32'd0);
    run_and_check("after_flush_divu_9_3", OPDIVU, 32'd9, 32'd3, 32'd3, LAT_FULL);

    // Asynchronous reset at CALC cycle 5.
    start_op(OPDIVU, 32'd100, 32'd7, acc_stall);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midreset_result", result, 32'd0);
    check("midreset_flags", {29'd0, busy, valid, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Result reuse: identical operands with a different selector.
    run_and_check("cache_div_1000_33", OPDIV, 32'd1000, 32'd33, 32'd30, LAT_FULL);
`ifdef DIV_RESULT_REUSE_EN
    run_and_check("cache_rem_hit", OPREM, 32'd1000, 32'd33, 32'd10, LAT_ONE);
`else
    run_and_check("cache_rem_hit", OPREM, 32'd1000, 32'd33, 32'd10, LAT_FULL);
`endif
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    run_and_check("cache_rem_after_flush", OPREM, 32'd1000, 32'd33, 32'd10, LAT_FULL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
